// File: rtl/sfcw_pkg.sv
// Shared types and helpers for the SFCW step sequencer.
package sfcw_pkg;

  localparam int FW_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    SETTLE = 2'd2,
    DWELL  = 2'd3
  } state_e;

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/step_edge_det.sv
// Rising-edge detector for the divided step clock (same clk_in domain).
module step_edge_det (
  input  logic clk_in,
  input  logic rst,
  input  logic step_clk,
  output logic rise
);

  logic step_clk_d_q;
  logic step_clk_d_d;

  assign step_clk_d_d = step_clk;

  // Reset value 1: the divider output is high out of reset, so no false edge.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      step_clk_d_q <= 1'b1;
    end else begin
      step_clk_d_q <= step_clk_d_d;
    end
  end

  assign rise = step_clk & ~step_clk_d_q;

endmodule

// File: rtl/sfcw_step_sequencer.sv
// SFCW sweep sequencer: frequency word per step edge, settle hold-off, sample window.
// Define SFCW_CONTINUOUS_EN to restart the sweep automatically after the last step.
module sfcw_step_sequencer
  import sfcw_pkg::*;
#(
  parameter int unsigned     N_STEPS       = 64,
  parameter int unsigned     FW            = FW_DEFAULT,
  parameter logic [FW-1:0]   F_START       = '0,
  parameter logic [FW-1:0]   F_STEP        = FW'(1),
  parameter int unsigned     SETTLE_CYCLES = 16
) (
  input  logic                             clk_in,
  input  logic                             rst,
  input  logic                             step_clk,
  input  logic                             start,
  input  logic                             stop,
  output logic [FW-1:0]                    freq_word,
  output logic                             freq_valid,
  output logic [idx_width(N_STEPS)-1:0]    step_idx,
  output logic                             sample_en,
  output logic                             sweep_done,
  output logic                             busy,
  output logic                             overrun
);

  localparam int IW = idx_width(N_STEPS);
  localparam int CW = idx_width(SETTLE_CYCLES);
  localparam logic [IW-1:0] LAST_IDX    = IW'(N_STEPS - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [FW-1:0] freq_word_q, freq_word_d;
  logic [IW-1:0] step_idx_q, step_idx_d;
  logic [CW-1:0] settle_cnt_q, settle_cnt_d;
  logic          freq_valid_q, freq_valid_d;
  logic          sweep_done_q, sweep_done_d;
  logic          overrun_q, overrun_d;
  logic          rise;
  logic          advance;

  step_edge_det u_edge (
    .clk_in   (clk_in),
    .rst      (rst),
    .step_clk (step_clk),
    .rise     (rise)
  );

  // freq_valid is a one-cycle strobe with no back-pressure: the synthesizer
  // must capture freq_word in the cycle freq_valid is high.
  always_comb begin
    state_d      = state_q;
    freq_word_d  = freq_word_q;
    step_idx_d   = step_idx_q;
    settle_cnt_d = settle_cnt_q;
    freq_valid_d = 1'b0;
    sweep_done_d = 1'b0;
    overrun_d    = overrun_q;
    advance      = 1'b0;

    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = ARM;
            overrun_d = 1'b0;
          end
        end
        ARM: begin
          if (rise) begin
            freq_word_d  = F_START;
            step_idx_d   = '0;
            freq_valid_d = 1'b1;
            settle_cnt_d = '0;
            state_d      = SETTLE;
          end
        end
        SETTLE: begin
          if (rise) begin
            overrun_d = 1'b1;
            advance   = 1'b1;
          end else if (settle_cnt_q == SETTLE_LAST) begin
            state_d = DWELL;
          end else begin
            settle_cnt_d = settle_cnt_q + CW'(1);
          end
        end
        DWELL: begin
          if (rise) begin
            advance = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A step edge from SETTLE or DWELL moves to the next word or ends the sweep.
    if (advance) begin
      settle_cnt_d = '0;
      if (step_idx_q != LAST_IDX) begin
        step_idx_d   = step_idx_q + IW'(1);
        freq_word_d  = freq_word_q + F_STEP;
        freq_valid_d = 1'b1;
        state_d      = SETTLE;
      end else begin
        sweep_done_d = 1'b1;
`ifdef SFCW_CONTINUOUS_EN
        freq_word_d  = F_START;
        step_idx_d   = '0;
        freq_valid_d = 1'b1;
        state_d      = SETTLE;
`else
        state_d      = IDLE;
`endif
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      freq_word_q  <= '0;
      step_idx_q   <= '0;
      settle_cnt_q <= '0;
      freq_valid_q <= 1'b0;
      sweep_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      freq_word_q  <= freq_word_d;
      step_idx_q   <= step_idx_d;
      settle_cnt_q <= settle_cnt_d;
      freq_valid_q <= freq_valid_d;
      sweep_done_q <= sweep_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign freq_word  = freq_word_q;
  assign freq_valid = freq_valid_q;
  assign step_idx   = step_idx_q;
  assign sample_en  = (state_q == DWELL);
  assign sweep_done = sweep_done_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule
